// File: rtl/stage_4_feeder.sv
// Operand-pair feeder for the stage_4 float accumulator: buffers pairs,
// issues one accumulate per pair and reports the final running total.
module stage_4_feeder #(
    parameter int FLOAT_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH       = 4,
    parameter int COUNT_WIDTH      = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic                        begin_acc,
    input  logic [COUNT_WIDTH-1:0]      pair_count,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [FLOAT_DATA_WIDTH-1:0] in_a,
    input  logic [FLOAT_DATA_WIDTH-1:0] in_b,
    output logic                        acc_start,
    output logic [FLOAT_DATA_WIDTH-1:0] acc_current_total,
    output logic [FLOAT_DATA_WIDTH-1:0] acc_add_one,
    output logic [FLOAT_DATA_WIDTH-1:0] acc_add_two,
    input  logic                        acc_done,
    input  logic [FLOAT_DATA_WIDTH-1:0] acc_new_total,
    output logic [FLOAT_DATA_WIDTH-1:0] result,
    output logic                        result_valid,
    output logic                        busy,
    output logic                        protocol_err
);
    localparam int W     = FLOAT_DATA_WIDTH;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t state_q, state_d;

    logic [W-1:0]       mem_a_q [FIFO_DEPTH];
    logic [W-1:0]       mem_a_d [FIFO_DEPTH];
    logic [W-1:0]       mem_b_q [FIFO_DEPTH];
    logic [W-1:0]       mem_b_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;

    logic [W-1:0]           total_q, total_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [W-1:0]           add_one_q, add_one_d;
    logic [W-1:0]           add_two_q, add_two_d;
    logic [W-1:0]           cur_total_q, cur_total_d;
    logic                   start_q, start_d;
    logic [W-1:0]           result_q, result_d;
    logic                   result_valid_q, result_valid_d;
    logic                   err_q, err_d;
    logic                   pend_q, pend_d;
    logic [W-1:0]           pend_total_q, pend_total_d;

    logic         full;
    logic         empty;
    logic         can_push;
    logic         push;
    logic         pop;
    logic         done_now;
    logic [W-1:0] done_total;

    assign full     = (occ_q == OCC_W'(FIFO_DEPTH));
    assign empty    = (occ_q == '0);
    assign can_push = rst && clk_en && !full;
    assign push     = in_valid && can_push;
    assign pop      = clk_en && (state_q == ISSUE) && !empty;

    // A completion seen while disabled is replayed from the pending flag.
    assign done_now   = acc_done || pend_q;
    assign done_total = pend_q ? pend_total_q : acc_new_total;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clk_en) begin
            unique case (state_q)
                IDLE: begin
                    if (begin_acc) begin
                        state_d = (pair_count == '0) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    if (!empty) state_d = WAIT;
                end
                WAIT: begin
                    if (done_now) begin
                        state_d = (remaining_q == COUNT_WIDTH'(1)) ? FINISH : ISSUE;
                    end
                end
                FINISH: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_a_d  = mem_a_q;
        mem_b_d  = mem_b_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_a_d[wr_ptr_q] = in_a;
            mem_b_d[wr_ptr_q] = in_b;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        total_d        = total_q;
        remaining_d    = remaining_q;
        add_one_d      = add_one_q;
        add_two_d      = add_two_q;
        cur_total_d    = cur_total_q;
        start_d        = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        err_d          = err_q;
        pend_d         = pend_q;
        pend_total_d   = pend_total_q;
        if (!clk_en) begin
            if (acc_done) begin
                pend_d       = 1'b1;
                pend_total_d = acc_new_total;
            end
        end else begin
            pend_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (begin_acc) begin
                        total_d     = '0;
                        remaining_d = pair_count;
                        err_d       = 1'b0;
                    end
                end
                ISSUE: begin
                    if (done_now) err_d = 1'b1;
                    if (!empty) begin
                        add_one_d   = mem_a_q[rd_ptr_q];
                        add_two_d   = mem_b_q[rd_ptr_q];
                        cur_total_d = total_q;
                        start_d     = 1'b1;
                    end
                end
                WAIT: begin
                    if (done_now) begin
                        total_d     = done_total;
                        remaining_d = remaining_q - COUNT_WIDTH'(1);
                    end
                end
                FINISH: begin
                    result_d       = total_q;
                    result_valid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        mem_a_q <= mem_a_d;
        mem_b_q <= mem_b_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            occ_q          <= '0;
            total_q        <= '0;
            remaining_q    <= '0;
            add_one_q      <= '0;
            add_two_q      <= '0;
            cur_total_q    <= '0;
            start_q        <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            pend_q         <= 1'b0;
            pend_total_q   <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occ_q          <= occ_d;
            total_q        <= total_d;
            remaining_q    <= remaining_d;
            add_one_q      <= add_one_d;
            add_two_q      <= add_two_d;
            cur_total_q    <= cur_total_d;
            start_q        <= start_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
            pend_q         <= pend_d;
            pend_total_q   <= pend_total_d;
        end
    end

    always_comb begin
        in_ready          = can_push;
        busy              = (state_q != IDLE);
        acc_start         = start_q;
        acc_current_total = cur_total_q;
        acc_add_one       = add_one_q;
        acc_add_two       = add_two_q;
        result            = result_q;
        result_valid      = result_valid_q;
        protocol_err      = err_q;
    end
endmodule

// File: tb/tb_stage_4_feeder.sv
// Scoreboard bench for stage_4_feeder with a 6-cycle accumulator model.
module tb_stage_4_feeder;
    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        begin_acc;
    logic [9:0]  pair_count;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        acc_start;
    logic [31:0] acc_current_total;
    logic [31:0] acc_add_one;
    logic [31:0] acc_add_two;
    logic        acc_done;
    logic [31:0] acc_new_total = 32'h0;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;
    logic        protocol_err;

    logic model_done = 1'b0;
    logic spur_done;
    assign acc_done = model_done | spur_done;

    always #5 clk = ~clk;

    stage_4_feeder dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .begin_acc(begin_acc), .pair_count(pair_count),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .acc_start(acc_start),
        .acc_current_total(acc_current_total),
        .acc_add_one(acc_add_one), .acc_add_two(acc_add_two),
        .acc_done(acc_done), .acc_new_total(acc_new_total),
        .result(result), .result_valid(result_valid),
        .busy(busy), .protocol_err(protocol_err)
    );

    typedef struct packed {
        logic [31:0] cur;
        logic [31:0] a;
        logic [31:0] b;
        logic        lat;
    } st_t;
    typedef struct packed {
        logic [31:0] val;
        logic        lat;
    } rs_t;

    st_t         sq[$];
    rs_t         sr[$];
    string       dq_name[$];
    logic [31:0] dq_act[$];
    logic [31:0] dq_exp[$];

    int n_chk = 0;
    int n_pass = 0;

    function automatic real sp2r(input logic [31:0] s);
        logic [63:0] d;
        if (s[30:0] == 31'h0) d = {s[31], 63'h0};
        else d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'h0) return {d[63], 31'h0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function void do_chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    function void add_chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        dq_name.push_back(nm);
        dq_act.push_back(act);
        dq_exp.push_back(exp);
    endfunction

    // Accumulator model: add_two is sampled at completion, like the real stage.
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_cur, m_a, m_b;
    logic        check_hold = 1'b1;

    always @(negedge clk) begin
        model_done = 1'b0;
        if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 1'b0;
                model_done = 1'b1;
                acc_new_total = r2sp(sp2r(m_cur) + sp2r(m_a) + sp2r(acc_add_two));
                if (check_hold) begin
                    add_chk("hold_total", acc_current_total, m_cur);
                    add_chk("hold_add_one", acc_add_one, m_a);
                    add_chk("hold_add_two", acc_add_two, m_b);
                end
            end
        end
        if (acc_start === 1'b1 && !m_busy) begin
            m_busy = 1'b1;
            m_cnt = 6;
            m_cur = acc_current_total;
            m_a = acc_add_one;
            m_b = acc_add_two;
        end
    end

    st_t  ms;
    rs_t  mr;
    logic prev_done = 1'b0;
    logic prev_begin = 1'b0;
    logic prev_rv = 1'b0;

    always begin
        @(posedge clk);
        #1;
        while (dq_name.size() > 0)
            do_chk(dq_name.pop_front(), dq_act.pop_front(), dq_exp.pop_front());
        if (acc_start === 1'b1) begin
            do_chk("start_expected", 32'(sq.size() > 0), 32'd1);
            if (sq.size() > 0) begin
                ms = sq.pop_front();
                do_chk("start_total", acc_current_total, ms.cur);
                do_chk("start_add_one", acc_add_one, ms.a);
                do_chk("start_add_two", acc_add_two, ms.b);
                if (ms.lat) do_chk("start_latency", 32'(prev_begin | prev_done), 32'd1);
            end
        end
        if (result_valid === 1'b1) begin
            do_chk("result_expected", 32'(sr.size() > 0), 32'd1);
            do_chk("result_pulse", 32'(prev_rv), 32'd0);
            if (sr.size() > 0) begin
                mr = sr.pop_front();
                do_chk("result_value", result, mr.val);
                if (mr.lat) do_chk("result_latency", 32'(prev_begin | prev_done), 32'd1);
            end
        end
        prev_done = (acc_done === 1'b1);
        prev_begin = (begin_acc === 1'b1);
        prev_rv = (result_valid === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int k = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (in_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        add_chk("push_timeout", 32'(k < 50), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic begin_run(input logic [9:0] pc);
        begin_acc = 1'b1;
        pair_count = pc;
        @(negedge clk);
        begin_acc = 1'b0;
    endtask

    task automatic wait_start();
        int k = 0;
        while (acc_start !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        add_chk("start_timeout", 32'(k < 40), 32'd1);
    endtask

    task automatic wait_done();
        int k = 0;
        while ((sr.size() != 0 || busy !== 1'b0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        add_chk("done_timeout", 32'(k < 300), 32'd1);
        tick(2);
    endtask

    localparam logic [31:0] F1 = 32'h3F800000;
    localparam logic [31:0] F2 = 32'h40000000;

    initial begin
        rst = 1'b0;
        clk_en = 1'b1;
        begin_acc = 1'b0;
        pair_count = '0;
        in_valid = 1'b1;
        in_a = F1;
        in_b = F2;
        spur_done = 1'b0;

        // reset with in_valid held high
        @(negedge clk);
        add_chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick(2);
        add_chk("rst_start", 32'(acc_start), 32'd0);
        add_chk("rst_total", acc_current_total, 32'd0);
        add_chk("rst_add_one", acc_add_one, 32'd0);
        add_chk("rst_add_two", acc_add_two, 32'd0);
        add_chk("rst_result", result, 32'd0);
        add_chk("rst_rv", 32'(result_valid), 32'd0);
        add_chk("rst_busy", 32'(busy), 32'd0);
        add_chk("rst_perr", 32'(protocol_err), 32'd0);
        rst = 1'b1;
        in_valid = 1'b0;
        tick(1);
        add_chk("post_rst_ready", 32'(in_ready), 32'd1);

        // single pair; FIFO must be empty so ISSUE stalls first
        sq.push_back('{cur: 32'h0, a: F1, b: F2, lat: 1'b0});
        sr.push_back('{val: 32'h40400000, lat: 1'b1});
        begin_run(10'd1);
        tick(4);
        add_chk("stall_busy", 32'(busy), 32'd1);
        push(F1, F2);
        wait_done();

        // three back-to-back pairs
        sq.push_back('{cur: 32'h0, a: F1, b: F1, lat: 1'b1});
        sq.push_back('{cur: 32'h40000000, a: F2, b: F2, lat: 1'b1});
        sq.push_back('{cur: 32'h40C00000, a: F1, b: F2, lat: 1'b1});
        sr.push_back('{val: 32'h41100000, lat: 1'b1});
        push(F1, F1);
        push(F2, F2);
        push(F1, F2);
        begin_run(10'd3);
        wait_done();

        // FIFO full, fifth pair accepted after first pop
        for (int i = 0; i < 4; i++) push(F1, F1);
        add_chk("full_ready", 32'(in_ready), 32'd0);
        sq.push_back('{cur: 32'h0, a: F1, b: F1, lat: 1'b1});
        sq.push_back('{cur: 32'h40000000, a: F1, b: F1, lat: 1'b1});
        sq.push_back('{cur: 32'h40800000, a: F1, b: F1, lat: 1'b1});
        sq.push_back('{cur: 32'h40C00000, a: F1, b: F1, lat: 1'b1});
        sq.push_back('{cur: 32'h41000000, a: F2, b: F2, lat: 1'b1});
        sr.push_back('{val: 32'h41400000, lat: 1'b1});
        in_valid = 1'b1;
        in_a = F2;
        in_b = F2;
        begin_run(10'd5);
        begin
            int k = 0;
            while (in_ready !== 1'b1 && k < 20) begin
                @(negedge clk);
                k++;
            end
            add_chk("fifth_timeout", 32'(k < 20), 32'd1);
        end
        add_chk("ready_with_pop", 32'(acc_start), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        add_chk("refull_ready", 32'(in_ready), 32'd0);
        wait_done();

        // zero pairs
        sr.push_back('{val: 32'h0, lat: 1'b1});
        begin_run(10'd0);
        wait_done();

        // spurious done while ISSUE waits for data
        sq.push_back('{cur: 32'h0, a: F1, b: F2, lat: 1'b0});
        sr.push_back('{val: 32'h40400000, lat: 1'b1});
        begin_run(10'd1);
        tick(2);
        spur_done = 1'b1;
        tick(1);
        spur_done = 1'b0;
        tick(1);
        add_chk("perr_set", 32'(protocol_err), 32'd1);
        push(F1, F2);
        wait_done();
        add_chk("perr_hold", 32'(protocol_err), 32'd1);
        sr.push_back('{val: 32'h0, lat: 1'b1});
        begin_run(10'd0);
        add_chk("perr_clear", 32'(protocol_err), 32'd0);
        wait_done();

        // completion arrives while disabled
        sq.push_back('{cur: 32'h0, a: F2, b: F1, lat: 1'b1});
        sr.push_back('{val: 32'h40400000, lat: 1'b0});
        push(F2, F1);
        begin_run(10'd1);
        wait_start();
        clk_en = 1'b0;
        tick(10);
        add_chk("dis_busy", 32'(busy), 32'd1);
        add_chk("dis_ready", 32'(in_ready), 32'd0);
        add_chk("dis_hold", acc_add_one, F2);
        clk_en = 1'b1;
        wait_done();

        // reset while waiting; the late completion must be ignored
        sq.push_back('{cur: 32'h0, a: F1, b: F1, lat: 1'b1});
        push(F1, F1);
        begin_run(10'd1);
        wait_start();
        tick(2);
        check_hold = 1'b0;
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        add_chk("midrst_busy", 32'(busy), 32'd0);
        add_chk("midrst_result", result, 32'd0);
        tick(10);
        add_chk("late_perr", 32'(protocol_err), 32'd0);
        add_chk("late_busy", 32'(busy), 32'd0);
        check_hold = 1'b1;

        add_chk("starts_left", 32'(sq.size()), 32'd0);
        add_chk("results_left", 32'(sr.size()), 32'd0);
        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
